// File: rtl/tribus_arbiter.sv
// ============================================================================
// Module  : tribus_arbiter
// Purpose : Round-robin owner of a shared tri-state bus: one-hot Buffer enables,
//           a hold limit, an all-off turnaround cycle and capture of the bus value.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tribus_arbiter #(
  parameter int DW       = 8,
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         i_req,
  input  logic [DW-1:0]        i_bus_in,
  output logic [N-1:0]         o_en,
  output logic [$clog2(N)-1:0] o_owner,
  output logic                 o_busy,
  output logic [DW-1:0]        o_data_q,
  output logic [$clog2(N)-1:0] o_data_src,
  output logic                 o_data_valid
);

  localparam int c_OW = $clog2(N);
  localparam int c_HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(MAX_HOLD - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_GRANT = 2'd1;
  localparam logic [1:0] c_TURN  = 2'd2;

  logic [1:0]      r_state;
  logic [N-1:0]    r_en;
  logic [c_OW-1:0] r_owner;
  logic [c_OW-1:0] r_last;
  logic [c_HW-1:0] r_hold_cnt;
  logic            r_busy;
  logic [DW-1:0]   r_data_q;
  logic [c_OW-1:0] r_data_src;
  logic            r_data_valid;

  logic [c_OW-1:0] w_winner;
  logic            w_found;
  logic [c_OW:0]   w_sum;
  logic            w_other;
  logic            w_release;

  // Scan last+1 .. last+N so the previous owner is considered only as the final candidate.
  always_comb begin
    w_winner = r_last;
    w_found  = 1'b0;
    w_sum    = '0;
    for (int k = 1; k <= N; k++) begin
      w_sum = {1'b0, r_last} + (c_OW + 1)'(k);
      if (w_sum >= (c_OW + 1)'(N)) begin
        w_sum = w_sum - (c_OW + 1)'(N);
      end
      if (!w_found && i_req[w_sum[c_OW-1:0]]) begin
        w_winner = w_sum[c_OW-1:0];
        w_found  = 1'b1;
      end
    end
  end

  assign w_other   = |(i_req & ~r_en);
  assign w_release = !i_req[r_owner] || ((r_hold_cnt == c_HOLD_LAST) && w_other);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_IDLE;
      r_en         <= '0;
      r_owner      <= '0;
      r_last       <= c_OW'(N - 1);
      r_hold_cnt   <= '0;
      r_busy       <= 1'b0;
      r_data_q     <= '0;
      r_data_src   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      case (r_state)
        c_IDLE, c_TURN: begin
          if (|i_req) begin
            r_state    <= c_GRANT;
            r_en       <= N'(1) << w_winner;
            r_owner    <= w_winner;
            r_hold_cnt <= '0;
            r_busy     <= 1'b1;
          end else begin
            r_state <= c_IDLE;
          end
        end
        c_GRANT: begin
          r_data_q     <= i_bus_in;
          r_data_src   <= r_owner;
          r_data_valid <= 1'b1;
          if (w_release) begin
            r_state <= c_TURN;
            r_en    <= '0;
            r_last  <= r_owner;
            r_busy  <= 1'b0;
          end else if (r_hold_cnt != c_HOLD_LAST) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_en    <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_en         = r_en;
  assign o_owner      = r_owner;
  assign o_busy       = r_busy;
  assign o_data_q     = r_data_q;
  assign o_data_src   = r_data_src;
  assign o_data_valid = r_data_valid;

endmodule

`default_nettype wire

// File: tb/tb_tribus_arbiter.sv
// ============================================================================
// Module  : tb_tribus_arbiter
// Purpose : Self-checking bench for tribus_arbiter (DW=8, N=4, MAX_HOLD=8).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tribus_arbiter;

  typedef struct {
    logic [3:0] req;
    logic [3:0] en;
    logic [1:0] owner;
    logic       busy;
    logic       dv;
    logic [7:0] dq;
    logic [1:0] src;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] i_req;
  logic [7:0] w_bus;
  logic [3:0] o_en;
  logic [1:0] o_owner;
  logic       o_busy;
  logic [7:0] o_data_q;
  logic [1:0] o_data_src;
  logic       o_data_valid;

  logic [7:0] drv [4];
  logic [3:0] r_prev_en;
  vec_t       exp_q [$];
  int         n_checks;
  int         n_errors;

  tribus_arbiter #(.DW(8), .N(4), .MAX_HOLD(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req        (i_req),
    .i_bus_in     (w_bus),
    .o_en         (o_en),
    .o_owner      (o_owner),
    .o_busy       (o_busy),
    .o_data_q     (o_data_q),
    .o_data_src   (o_data_src),
    .o_data_valid (o_data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer models: only the enabled driver puts its value on the bus.
  always_comb begin
    w_bus = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (o_en[i]) w_bus = drv[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] req, input logic [3:0] en, input logic [1:0] owner,
                              input logic busy, input logic dv, input logic [7:0] dq,
                              input logic [1:0] src);
    vec_t v;
    v.req = req; v.en = en; v.owner = owner; v.busy = busy;
    v.dv = dv; v.dq = dq; v.src = src;
    return v;
  endfunction

  task automatic check_out();
    vec_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk("en", 32'(o_en), 32'(e.en));
    chk("owner", 32'(o_owner), 32'(e.owner));
    chk("busy", 32'(o_busy), 32'(e.busy));
    chk("data_valid", 32'(o_data_valid), 32'(e.dv));
    if (e.dv) begin
      chk("data_q", 32'(o_data_q), 32'(e.dq));
      chk("data_src", 32'(o_data_src), 32'(e.src));
    end
    chk("en_onehot", 32'($countones(o_en) <= 1), 32'd1);
    chk("en_no_handover",
        32'((r_prev_en != 4'b0) && (o_en != 4'b0) && (r_prev_en != o_en)), 32'd0);
    r_prev_en = o_en;
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    i_req = v.req;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    i_req = 4'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    r_prev_en = 4'b0;
  endtask

  vec_t t1 [8];

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    r_prev_en = 4'b0;
    drv[0] = 8'hA0; drv[1] = 8'hA1; drv[2] = 8'hA5; drv[3] = 8'hA3;
    i_req = 4'b0;
    rst_n = 1'b0;

    // Single requester 2 for five cycles, then turnaround and idle.
    t1[0] = mk(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 8'h00, 2'd0);
    t1[1] = mk(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5, 2'd2);
    t1[2] = mk(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5, 2'd2);
    t1[3] = mk(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5, 2'd2);
    t1[4] = mk(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5, 2'd2);
    t1[5] = mk(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b1, 8'hA5, 2'd2);
    t1[6] = mk(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 8'h00, 2'd0);
    t1[7] = mk(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 8'h00, 2'd0);

    @(posedge clk); @(posedge clk); #1;
    chk("rst_en", 32'(o_en), 32'd0);
    chk("rst_owner", 32'(o_owner), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_data_q", 32'(o_data_q), 32'd0);
    chk("rst_data_src", 32'(o_data_src), 32'd0);
    chk("rst_data_valid", 32'(o_data_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) step(t1[i]);

    // All four requesting: owners 0,1,2,3,0 for 8 cycles each with a gap.
    do_reset();
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 8; c++) begin
        step(mk(4'b1111, 4'(1 << (g % 4)), 2'(g % 4), 1'b1, (c > 0), drv[g % 4], 2'(g % 4)));
      end
      step(mk(4'b1111, 4'b0000, 2'(g % 4), 1'b0, 1'b1, drv[g % 4], 2'(g % 4)));
    end

    // Sole requester 1 keeps the bus; a late requester then forces the saturated hold to end.
    do_reset();
    step(mk(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, 8'h00, 2'd0));
    for (int c = 1; c < 20; c++) step(mk(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1, 8'hA1, 2'd1));
    step(mk(4'b0011, 4'b0000, 2'd1, 1'b0, 1'b1, 8'hA1, 2'd1));
    step(mk(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, 8'h00, 2'd0));
    step(mk(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1, 8'hA0, 2'd0));
    step(mk(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00, 2'd0));

    // Asynchronous reset while owner 3 holds the bus.
    do_reset();
    step(mk(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, 8'h00, 2'd0));
    step(mk(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1, 8'hA3, 2'd3));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_en", 32'(o_en), 32'd0);
    chk("async_rst_busy", 32'(o_busy), 32'd0);
    chk("async_rst_valid", 32'(o_data_valid), 32'd0);
    @(negedge clk);
    i_req = 4'b0;
    rst_n = 1'b1;
    r_prev_en = 4'b0;
    step(mk(4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0, 8'h00, 2'd0));

    // Owner 0 drops in the same cycle requester 2 arrives.
    step(mk(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, 8'hA0, 2'd0));
    step(mk(4'b0100, 4'b0000, 2'd0, 1'b0, 1'b1, 8'hA0, 2'd0));
    step(mk(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 8'h00, 2'd0));
    step(mk(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5, 2'd2));
    step(mk(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b1, 8'hA5, 2'd2));
    step(mk(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 8'h00, 2'd0));

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
